// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the PMOD frequency meter.
// FSM state encoding plus a constant-foldable clog2 used to size the gate/high counters.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GATE  = 2'd1,
      ST_LATCH = 2'd2
   } fm_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with a rising-edge detector on its output.
// LEVEL is the synchronized value; RISE is high for one cycle when LEVEL goes 0 -> 1.
module sig_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic LEVEL,
   output logic RISE
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_d_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q    <= '0;
         level_d_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], D};
         level_d_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign LEVEL = sync_q[SYNC_STAGES-1];
   assign RISE  = LEVEL & ~level_d_q;

endmodule

// File: rtl/pmod_freq_meter.sv
// Gated frequency/duty meter for one PMOD divider output: counts rising edges and high cycles per window.
// Optional macro FREQ_METER_PERIOD_EN adds PERIOD, the spacing of the last two edges in the window.
//
// state    | meaning
// ST_IDLE  | counters held at 0, waiting for EN
// ST_GATE  | accumulating for GATE_CYCLES cycles (BUSY=1)
// ST_LATCH | one dead cycle, results visible with VALID=1
module pmod_freq_meter
   import freq_meter_pkg::*;
#(
   parameter int  GATE_CYCLES = 1000,
   parameter int  CNT_W       = 16,
   parameter int  SYNC_STAGES = 2,
   localparam int GW          = clog2(GATE_CYCLES + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SIG_IN,
   input  logic             EN,
   output logic [CNT_W-1:0] COUNT,
   output logic [GW-1:0]    HIGH_CYC,
   output logic             OVF,
   output logic             VALID,
   output logic             BUSY
`ifdef FREQ_METER_PERIOD_EN
   ,
   output logic [GW-1:0]    PERIOD
`endif
);

   localparam logic [CNT_W-1:0] EDGE_MAX  = '1;
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);

   fm_state_e        state_q, state_d;
   logic             sig_s, sig_rise;
   logic             acc_run, gate_last, load_out;
   logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, edge_nxt;
   logic [GW-1:0]    high_cnt_q, high_cnt_d, high_nxt;
   logic             ovf_acc_q, ovf_acc_d, ovf_nxt;
   logic [CNT_W-1:0] count_q;
   logic [GW-1:0]    high_cyc_q;
   logic             ovf_q;

   sig_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .CLK  (CLK),
      .RST  (RST),
      .D    (SIG_IN),
      .LEVEL(sig_s),
      .RISE (sig_rise)
   );

   assign acc_run   = (state_q == ST_GATE) && EN;
   assign gate_last = (gate_cnt_q == GATE_LAST);
   // Results load on the edge into LATCH so they are already valid while VALID is high.
   assign load_out  = acc_run && gate_last;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (EN) state_d = ST_GATE;
         end
         ST_GATE: begin
            if (!EN)            state_d = ST_IDLE;
            else if (gate_last) state_d = ST_LATCH;
         end
         ST_LATCH: begin
            state_d = EN ? ST_GATE : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      edge_nxt   = edge_cnt_q;
      ovf_nxt    = ovf_acc_q;
      high_nxt   = high_cnt_q + GW'(sig_s);
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      high_cnt_d = '0;
      ovf_acc_d  = 1'b0;
      if (sig_rise) begin
         if (edge_cnt_q == EDGE_MAX) ovf_nxt = 1'b1;
         else                        edge_nxt = edge_cnt_q + CNT_W'(1);
      end
      // Outside a running window (and on its last cycle) everything returns to zero.
      if (acc_run && !gate_last) begin
         gate_cnt_d = gate_cnt_q + GW'(1);
         edge_cnt_d = edge_nxt;
         high_cnt_d = high_nxt;
         ovf_acc_d  = ovf_nxt;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         high_cnt_q <= '0;
         ovf_acc_q  <= 1'b0;
      end else begin
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         high_cnt_q <= high_cnt_d;
         ovf_acc_q  <= ovf_acc_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_q    <= '0;
         high_cyc_q <= '0;
         ovf_q      <= 1'b0;
      end else if (load_out) begin
         count_q    <= edge_nxt;
         high_cyc_q <= high_nxt;
         ovf_q      <= ovf_nxt;
      end
   end

   assign COUNT    = count_q;
   assign HIGH_CYC = high_cyc_q;
   assign OVF      = ovf_q;
   assign VALID    = (state_q == ST_LATCH);
   assign BUSY     = (state_q == ST_GATE);

`ifdef FREQ_METER_PERIOD_EN
   logic [GW-1:0] per_cnt_q, per_cnt_d;
   logic [GW-1:0] per_acc_q, per_acc_d, per_nxt;
   logic [GW-1:0] period_q;

   // per_cnt only runs once the first edge of the window has been seen.
   always_comb begin
      per_cnt_d = '0;
      per_acc_d = '0;
      per_nxt   = per_acc_q;
      if (sig_rise && (edge_cnt_q != '0)) per_nxt = per_cnt_q;
      if (acc_run && !gate_last) begin
         per_acc_d = per_nxt;
         if (sig_rise) begin
            per_cnt_d = GW'(1);
         end else if (edge_cnt_q != '0) begin
            per_cnt_d = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + GW'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         per_cnt_q <= '0;
         per_acc_q <= '0;
         period_q  <= '0;
      end else begin
         per_cnt_q <= per_cnt_d;
         per_acc_q <= per_acc_d;
         if (load_out) period_q <= per_nxt;
      end
   end

   assign PERIOD = period_q;
`endif

endmodule

// File: tb/tb_pmod_freq_meter.sv
// Self-checking bench for pmod_freq_meter: a history of sampled SIG_IN values feeds a window model.
module tb_pmod_freq_meter;

   localparam int G      = 1000;
   localparam int CW     = 16;
   localparam int S      = 2;
   localparam int GWB    = $clog2(G + 1);
   localparam int G_SAT  = 100;
   localparam int CW_SAT = 4;
   localparam int GW_SAT = $clog2(G_SAT + 1);

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic SIG_IN = 1'b0;
   logic EN = 1'b0;
   logic EN_SAT = 1'b0;

   logic [CW-1:0]     COUNT;
   logic [GWB-1:0]    HIGH_CYC;
   logic              OVF, VALID, BUSY;
   logic [CW_SAT-1:0] COUNT_SAT;
   logic [GW_SAT-1:0] HIGH_SAT;
   logic              OVF_SAT, VALID_SAT, BUSY_SAT;
`ifdef FREQ_METER_PERIOD_EN
   logic [GWB-1:0]    PERIOD;
   logic [GW_SAT-1:0] PERIOD_SAT;
`endif

   pmod_freq_meter #(.GATE_CYCLES(G), .CNT_W(CW), .SYNC_STAGES(S)) dut (
      .CLK(CLK), .RST(RST), .SIG_IN(SIG_IN), .EN(EN),
      .COUNT(COUNT), .HIGH_CYC(HIGH_CYC), .OVF(OVF), .VALID(VALID), .BUSY(BUSY)
`ifdef FREQ_METER_PERIOD_EN
      , .PERIOD(PERIOD)
`endif
   );

   pmod_freq_meter #(.GATE_CYCLES(G_SAT), .CNT_W(CW_SAT), .SYNC_STAGES(S)) dut_sat (
      .CLK(CLK), .RST(RST), .SIG_IN(SIG_IN), .EN(EN_SAT),
      .COUNT(COUNT_SAT), .HIGH_CYC(HIGH_SAT), .OVF(OVF_SAT), .VALID(VALID_SAT), .BUSY(BUSY_SAT)
`ifdef FREQ_METER_PERIOD_EN
      , .PERIOD(PERIOD_SAT)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit sig_hist [0:65535];
   int sig_mode  = 0;
   bit sig_level = 1'b0;
   int sig_half  = 5;
   int sig_ph    = 0;
   int exp_cnt = 0, exp_hi = 0, exp_ovf = 0;

   always #5 CLK = ~CLK;

   // cyc == k during the cycle after posedge k; sig_hist[k] is SIG_IN as sampled on that edge.
   always @(posedge CLK) begin
      cyc = cyc + 1;
      if (cyc < 65536) sig_hist[cyc] = SIG_IN;
   end

   initial begin
      forever begin
         @(negedge CLK);
         case (sig_mode)
            0: SIG_IN = sig_level;
            1: begin
               sig_ph = sig_ph + 1;
               if (sig_ph >= sig_half) begin
                  sig_ph = 0;
                  SIG_IN = ~SIG_IN;
               end
            end
            default: SIG_IN = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Window opened with EN first sampled on edge e covers cycles e..e+g-1; the synchronized
   // level in cycle c is the pin value S-1 edges earlier.
   function automatic void model(input int e, input int g, input int cw,
                                 output int cnt, output int hi, output int ovf, output int per);
      int maxv;
      int last;
      bit s;
      bit sd;
      maxv = (1 << cw) - 1;
      last = -1;
      cnt = 0; hi = 0; ovf = 0; per = 0;
      for (int c = e; c < e + g; c++) begin
         s  = sig_hist[c - S + 1];
         sd = sig_hist[c - S];
         hi = hi + int'(s);
         if (s && !sd) begin
            if (cnt == maxv) ovf = 1;
            else cnt = cnt + 1;
            if (last >= 0) per = c - last;
            last = c;
         end
      end
   endfunction

   task automatic set_toggle(input int half, input int ph);
      sig_mode = 1;
      sig_half = half;
      sig_ph   = ph;
   endtask

   task automatic wait_valid(input bit sat, input int budget, output int vc);
      vc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if ((sat ? VALID_SAT : VALID) === 1'b1) begin
            vc = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset_state();
      repeat (3) @(negedge CLK);
      n_checks++;
      if ({COUNT, HIGH_CYC, OVF, VALID, BUSY} !== '0)
         $display("FAIL reset_held: count=%0d high=%0d ovf=%b valid=%b busy=%b want all 0",
                  COUNT, HIGH_CYC, OVF, VALID, BUSY);
      else n_pass++;
      RST = 1'b0;
      repeat (8) @(negedge CLK);
      n_checks++;
      if ({COUNT, HIGH_CYC, OVF, VALID, BUSY, COUNT_SAT, VALID_SAT, BUSY_SAT} !== '0)
         $display("FAIL reset_idle: count=%0d valid=%b busy=%b sat_count=%0d want all 0",
                  COUNT, VALID, BUSY, COUNT_SAT);
      else n_pass++;
`ifdef FREQ_METER_PERIOD_EN
      n_checks++;
      if (PERIOD !== '0) $display("FAIL reset_period: got %0d want 0", PERIOD);
      else n_pass++;
`endif
   endtask

   task automatic test_nominal();
      int e, vc;
      set_toggle(5, 0);
      repeat (20) @(negedge CLK);
      e  = cyc + 1;
      EN = 1'b1;
      wait_valid(1'b0, G + 50, vc);
      EN = 1'b0;
      n_checks++;
      if (vc != e + G) $display("FAIL nominal_latency: valid at cycle %0d want %0d", vc, e + G);
      else n_pass++;
      n_checks++;
      if (COUNT !== CW'(100)) $display("FAIL nominal_count: got %0d want 100", COUNT);
      else n_pass++;
      n_checks++;
      if (HIGH_CYC !== GWB'(500)) $display("FAIL nominal_high: got %0d want 500", HIGH_CYC);
      else n_pass++;
      n_checks++;
      if (OVF !== 1'b0) $display("FAIL nominal_ovf: got %b want 0", OVF);
      else n_pass++;
`ifdef FREQ_METER_PERIOD_EN
      n_checks++;
      if (PERIOD !== GWB'(10)) $display("FAIL nominal_period: got %0d want 10", PERIOD);
      else n_pass++;
`endif
      exp_cnt = 100; exp_hi = 500; exp_ovf = 0;
      @(negedge CLK);
      n_checks++;
      if (VALID !== 1'b0 || BUSY !== 1'b0)
         $display("FAIL nominal_pulse: valid=%b busy=%b want 0 0 after latch", VALID, BUSY);
      else n_pass++;
   endtask

   task automatic test_reset();
      int nv;
      set_toggle(3, 0);
      EN = 1'b1;
      repeat (300) @(negedge CLK);
      n_checks++;
      if (BUSY !== 1'b1) $display("FAIL reset_busy_before: got %b want 1", BUSY);
      else n_pass++;
      #2 RST = 1'b1;
      #1;
      n_checks++;
      if ({COUNT, HIGH_CYC, OVF, VALID, BUSY} !== '0)
         $display("FAIL reset_async: count=%0d high=%0d ovf=%b valid=%b busy=%b want all 0",
                  COUNT, HIGH_CYC, OVF, VALID, BUSY);
      else n_pass++;
      EN = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      nv = 0;
      for (int i = 0; i < G + 100; i++) begin
         @(negedge CLK);
         if (VALID === 1'b1 || BUSY === 1'b1) nv++;
      end
      n_checks++;
      if (nv != 0) $display("FAIL reset_no_valid: %0d active cycles want 0", nv);
      else n_pass++;
      exp_cnt = 0; exp_hi = 0; exp_ovf = 0;
   endtask

   task automatic test_back_to_back();
      int e, vc, mc, mh, mo, mp;
      @(negedge CLK);
      set_toggle(10, $urandom_range(0, 9));
      repeat (25) @(negedge CLK);
      e  = cyc + 1;
      EN = 1'b1;
      for (int w = 0; w < 3; w++) begin
         wait_valid(1'b0, G + 50, vc);
         if (w == 2) EN = 1'b0;
         model(e + w * (G + 1), G, CW, mc, mh, mo, mp);
         n_checks++;
         if (vc != e + G + w * (G + 1))
            $display("FAIL b2b_spacing[%0d]: valid at cycle %0d want %0d", w, vc, e + G + w * (G + 1));
         else n_pass++;
         n_checks++;
         if (COUNT !== CW'(mc) || COUNT < 49 || COUNT > 50)
            $display("FAIL b2b_count[%0d]: got %0d want %0d", w, COUNT, mc);
         else n_pass++;
         n_checks++;
         if (HIGH_CYC !== GWB'(mh) || HIGH_CYC < 500 || HIGH_CYC > 501)
            $display("FAIL b2b_high[%0d]: got %0d want %0d", w, HIGH_CYC, mh);
         else n_pass++;
`ifdef FREQ_METER_PERIOD_EN
         n_checks++;
         if (PERIOD !== GWB'(mp)) $display("FAIL b2b_period[%0d]: got %0d want %0d", w, PERIOD, mp);
         else n_pass++;
`endif
         exp_cnt = mc; exp_hi = mh; exp_ovf = mo;
      end
   endtask

   task automatic test_saturation();
      int e, vc, mc, mh, mo, mp;
      for (int w = 0; w < 2; w++) begin
         set_toggle(w == 0 ? 1 : 20, 0);
         repeat (10) @(negedge CLK);
         e      = cyc + 1;
         EN_SAT = 1'b1;
         wait_valid(1'b1, G_SAT + 50, vc);
         EN_SAT = 1'b0;
         model(e, G_SAT, CW_SAT, mc, mh, mo, mp);
         n_checks++;
         if (vc != e + G_SAT) $display("FAIL sat_latency[%0d]: valid at %0d want %0d", w, vc, e + G_SAT);
         else n_pass++;
         if (w == 0) begin
            n_checks++;
            if (COUNT_SAT !== 4'd15 || OVF_SAT !== 1'b1 || HIGH_SAT !== GW_SAT'(50))
               $display("FAIL sat_full: count=%0d ovf=%b high=%0d want 15 1 50", COUNT_SAT, OVF_SAT, HIGH_SAT);
            else n_pass++;
         end else begin
            n_checks++;
            if (COUNT_SAT !== CW_SAT'(mc) || OVF_SAT !== 1'(mo) || HIGH_SAT !== GW_SAT'(mh))
               $display("FAIL sat_clear: count=%0d ovf=%b high=%0d want %0d %0d %0d",
                        COUNT_SAT, OVF_SAT, HIGH_SAT, mc, mo, mh);
            else n_pass++;
         end
`ifdef FREQ_METER_PERIOD_EN
         n_checks++;
         if (PERIOD_SAT !== GW_SAT'(mp)) $display("FAIL sat_period[%0d]: got %0d want %0d", w, PERIOD_SAT, mp);
         else n_pass++;
`endif
      end
   endtask

   task automatic test_abort();
      int e, vc, nv, mc, mh, mo, mp;
      set_toggle($urandom_range(4, 12), 0);
      repeat (10) @(negedge CLK);
      e  = cyc + 1;
      EN = 1'b1;
      for (int i = 0; i < G && cyc < e + 400; i++) @(negedge CLK);
      EN = 1'b0;
      nv = 0;
      for (int i = 0; i < G + 200; i++) begin
         @(negedge CLK);
         if (VALID === 1'b1) nv++;
      end
      n_checks++;
      if (nv != 0 || BUSY !== 1'b0) $display("FAIL abort_no_valid: valids=%0d busy=%b want 0 0", nv, BUSY);
      else n_pass++;
      n_checks++;
      if (COUNT !== CW'(exp_cnt) || HIGH_CYC !== GWB'(exp_hi) || OVF !== 1'(exp_ovf))
         $display("FAIL abort_hold: count=%0d high=%0d ovf=%b want %0d %0d %0d",
                  COUNT, HIGH_CYC, OVF, exp_cnt, exp_hi, exp_ovf);
      else n_pass++;
      e  = cyc + 1;
      EN = 1'b1;
      wait_valid(1'b0, G + 50, vc);
      EN = 1'b0;
      model(e, G, CW, mc, mh, mo, mp);
      n_checks++;
      if (vc != e + G || COUNT !== CW'(mc) || HIGH_CYC !== GWB'(mh))
         $display("FAIL abort_fresh: valid_at=%0d count=%0d high=%0d want %0d %0d %0d",
                  vc, COUNT, HIGH_CYC, e + G, mc, mh);
      else n_pass++;
      exp_cnt = mc; exp_hi = mh; exp_ovf = mo;
   endtask

   task automatic test_static();
      int e, vc;
      for (int w = 0; w < 2; w++) begin
         sig_mode  = 0;
         sig_level = (w == 0);
         repeat (10) @(negedge CLK);
         e  = cyc + 1;
         EN = 1'b1;
         wait_valid(1'b0, G + 50, vc);
         EN = 1'b0;
         n_checks++;
         if (vc != e + G || COUNT !== '0 || HIGH_CYC !== GWB'(w == 0 ? G : 0) || OVF !== 1'b0)
            $display("FAIL static[%0d]: valid_at=%0d count=%0d high=%0d ovf=%b want %0d 0 %0d 0",
                     w, vc, COUNT, HIGH_CYC, OVF, e + G, (w == 0 ? G : 0));
         else n_pass++;
`ifdef FREQ_METER_PERIOD_EN
         n_checks++;
         if (PERIOD !== '0) $display("FAIL static_period[%0d]: got %0d want 0", w, PERIOD);
         else n_pass++;
`endif
      end
   endtask

   task automatic test_random();
      int e, vc, mc, mh, mo, mp;
      for (int w = 0; w < 4; w++) begin
         if (w < 2) set_toggle($urandom_range(2, 37), 0);
         else sig_mode = 2;
         repeat ($urandom_range(5, 30)) @(negedge CLK);
         e  = cyc + 1;
         EN = 1'b1;
         wait_valid(1'b0, G + 50, vc);
         EN = 1'b0;
         model(e, G, CW, mc, mh, mo, mp);
         n_checks++;
         if (vc != e + G || COUNT !== CW'(mc) || HIGH_CYC !== GWB'(mh) || OVF !== 1'(mo))
            $display("FAIL random[%0d]: valid_at=%0d count=%0d high=%0d ovf=%b want %0d %0d %0d %0d",
                     w, vc, COUNT, HIGH_CYC, OVF, e + G, mc, mh, mo);
         else n_pass++;
`ifdef FREQ_METER_PERIOD_EN
         n_checks++;
         if (PERIOD !== GWB'(mp)) $display("FAIL random_period[%0d]: got %0d want %0d", w, PERIOD, mp);
         else n_pass++;
`endif
      end
   endtask

   initial begin
      test_reset_state();
      test_nominal();
      test_reset();
      test_back_to_back();
      test_saturation();
      test_abort();
      test_static();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
